// File: rtl/rgb888_to_gray_meas_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb888_to_gray_meas_if
// Purpose  : Video stream bundle for the RGB888 -> luma converter: RGB input
//            stream, luma output stream and end-of-frame resolution report.
// Revision : 1.0 - initial release
// ============================================================================
interface rgb888_to_gray_meas_if #(
  parameter int CNT_W = 12
) ();

  logic             pre_img_vsync;
  logic             pre_img_hsync;
  logic             pre_img_valid;
  logic [7:0]       pre_img_red;
  logic [7:0]       pre_img_green;
  logic [7:0]       pre_img_blue;

  logic             post_img_vsync;
  logic             post_img_hsync;
  logic             post_img_valid;
  logic [7:0]       post_img_data;

  logic [CNT_W-1:0] frame_width;
  logic [CNT_W-1:0] frame_height;
  logic             frame_done;
  logic             line_len_err;

  // Video source / result sink side
  modport master (
    output pre_img_vsync, pre_img_hsync, pre_img_valid,
           pre_img_red, pre_img_green, pre_img_blue,
    input  post_img_vsync, post_img_hsync, post_img_valid, post_img_data,
           frame_width, frame_height, frame_done, line_len_err
  );

  // Converter side
  modport slave (
    input  pre_img_vsync, pre_img_hsync, pre_img_valid,
           pre_img_red, pre_img_green, pre_img_blue,
    output post_img_vsync, post_img_hsync, post_img_valid, post_img_data,
           frame_width, frame_height, frame_done, line_len_err
  );

endinterface
`default_nettype wire

// File: rtl/rgb888_to_gray_meas.sv
`default_nettype none
// ============================================================================
// Module   : rgb888_to_gray_meas
// Purpose  : RGB888 to 8-bit BT.601 luma, fixed 3-cycle pipeline with aligned
//            syncs, plus per-frame active resolution measurement and a
//            line-length consistency flag reported at end of frame.
// Revision : 1.0 - initial release
// ============================================================================
module rgb888_to_gray_meas #(
  parameter int CNT_W  = 12,
  parameter int COEF_R = 77,   // Q0.8, COEF_R+COEF_G+COEF_B must be 256
  parameter int COEF_G = 150,
  parameter int COEF_B = 29
) (
  input logic                 clk,
  input logic                 rst_n,
  rgb888_to_gray_meas_if.slave vif
);

  localparam logic [7:0]       C_R     = COEF_R[7:0];
  localparam logic [7:0]       C_G     = COEF_G[7:0];
  localparam logic [7:0]       C_B     = COEF_B[7:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // --------------------------------------------------------------------------
  // Luma pipeline (free-running, not gated by valid)
  // --------------------------------------------------------------------------
  logic [15:0] prod_r, prod_g, prod_b;
  logic [16:0] sum_s2;
  logic [7:0]  data_s3;
  logic [8:0]  rnd_shr;
  logic [2:0]  vs_dl, hs_dl, va_dl;

  // Rounded and scaled sum; bit 8 set means the result exceeds 8 bits
  assign rnd_shr = 9'((sum_s2 + 17'd128) >> 8);

  // Three pipeline stages: products, sum, round + saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r  <= '0;
      prod_g  <= '0;
      prod_b  <= '0;
      sum_s2  <= '0;
      data_s3 <= '0;
    end else begin
      prod_r  <= 16'(vif.pre_img_red)   * 16'(C_R);
      prod_g  <= 16'(vif.pre_img_green) * 16'(C_G);
      prod_b  <= 16'(vif.pre_img_blue)  * 16'(C_B);
      sum_s2  <= 17'(prod_r) + 17'(prod_g) + 17'(prod_b);
      data_s3 <= rnd_shr[8] ? 8'hFF : rnd_shr[7:0];
    end
  end

  // Sync delay lines, three registers deep to match the data path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_dl <= '0;
      hs_dl <= '0;
      va_dl <= '0;
    end else begin
      vs_dl <= {vs_dl[1:0], vif.pre_img_vsync};
      hs_dl <= {hs_dl[1:0], vif.pre_img_hsync};
      va_dl <= {va_dl[1:0], vif.pre_img_valid};
    end
  end

  assign vif.post_img_vsync = vs_dl[2];
  assign vif.post_img_hsync = hs_dl[2];
  assign vif.post_img_valid = va_dl[2];
  assign vif.post_img_data  = data_s3;

  // --------------------------------------------------------------------------
  // Resolution measurement (input side)
  // --------------------------------------------------------------------------
  logic             started;   // edge detectors are trusted one cycle after reset
  logic             armed;     // a full frame has begun since reset
  logic             vs_d, hs_d;
  logic [CNT_W-1:0] pix_cnt, line_cnt, first_len;
  logic             err_acc;
  logic [CNT_W-1:0] width_q, height_q;
  logic             err_q, done_q;

  logic             vs_rise, vs_fall, hs_rise, hs_fall, pix_en;
  logic [CNT_W-1:0] line_nxt, first_nxt;
  logic             err_nxt;

  assign vs_rise = started &  vif.pre_img_vsync & ~vs_d;
  assign vs_fall = started & ~vif.pre_img_vsync &  vs_d;
  assign hs_rise = started &  vif.pre_img_hsync & ~hs_d;
  assign hs_fall = started & ~vif.pre_img_hsync &  hs_d;
  assign pix_en  = vif.pre_img_valid & vif.pre_img_hsync & vif.pre_img_vsync;

  // Line accounting for this cycle; also feeds the frame latch so a line
  // ending together with the frame is still included
  always_comb begin
    line_nxt  = line_cnt;
    first_nxt = first_len;
    err_nxt   = err_acc;
    if (hs_fall && (pix_cnt != '0)) begin
      if (line_cnt != CNT_MAX) line_nxt = line_cnt + 1'b1;
      if (line_cnt == '0)            first_nxt = pix_cnt;
      else if (pix_cnt != first_len) err_nxt   = 1'b1;
    end
  end

  // Counters, edge history and end-of-frame result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      armed     <= 1'b0;
      vs_d      <= 1'b0;
      hs_d      <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      first_len <= '0;
      err_acc   <= 1'b0;
      width_q   <= '0;
      height_q  <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      started <= 1'b1;
      vs_d    <= vif.pre_img_vsync;
      hs_d    <= vif.pre_img_hsync;
      done_q  <= 1'b0;

      if (hs_rise)
        pix_cnt <= pix_en ? CNT_W'(1) : '0;
      else if (pix_en && (pix_cnt != CNT_MAX))
        pix_cnt <= pix_cnt + 1'b1;

      if (vs_rise) begin
        armed     <= 1'b1;
        line_cnt  <= '0;
        first_len <= '0;
        err_acc   <= 1'b0;
      end else begin
        line_cnt  <= line_nxt;
        first_len <= first_nxt;
        err_acc   <= err_nxt;
      end

      if (vs_fall && armed) begin
        width_q  <= first_nxt;
        height_q <= line_nxt;
        err_q    <= err_nxt;
        done_q   <= 1'b1;
      end
    end
  end

  assign vif.frame_width  = width_q;
  assign vif.frame_height = height_q;
  assign vif.line_len_err = err_q;
  assign vif.frame_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb888_to_gray_meas.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb888_to_gray_meas
// Purpose  : Directed self-checking bench for rgb888_to_gray_meas (12-bit and
//            4-bit counter instances driven with the same stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb888_to_gray_meas;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgb888_to_gray_meas_if #(.CNT_W(12)) vif ();
  rgb888_to_gray_meas_if #(.CNT_W(4))  vif4 ();

  assign vif4.pre_img_vsync = vif.pre_img_vsync;
  assign vif4.pre_img_hsync = vif.pre_img_hsync;
  assign vif4.pre_img_valid = vif.pre_img_valid;
  assign vif4.pre_img_red   = vif.pre_img_red;
  assign vif4.pre_img_green = vif.pre_img_green;
  assign vif4.pre_img_blue  = vif.pre_img_blue;

  rgb888_to_gray_meas #(.CNT_W(12)) u_dut (.clk(clk), .rst_n(rst_n), .vif(vif));
  rgb888_to_gray_meas #(.CNT_W(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .vif(vif4));

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int done4_cnt = 0;
  logic [10:0] hist [3];   // {vsync, hsync, valid, luma} of recent inputs

  function automatic logic [7:0] luma(input logic [7:0] r, g, b);
    int s;
    s = (int'(r) * 77 + int'(g) * 150 + int'(b) * 29 + 128) / 256;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, then compare the delayed stream with the history
  task automatic drive(input bit vs, input bit hs, input bit va,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    vif.pre_img_vsync = vs;
    vif.pre_img_hsync = hs;
    vif.pre_img_valid = va;
    vif.pre_img_red   = r;
    vif.pre_img_green = g;
    vif.pre_img_blue  = b;
    @(posedge clk);
    #1;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {vs, hs, va, luma(r, g, b)};
    if (!rst_n) begin
      hist[0] = '0;
      hist[1] = '0;
      hist[2] = '0;
    end
    check("post_sync", {vif.post_img_vsync, vif.post_img_hsync, vif.post_img_valid},
          hist[2][10:8]);
    if (hist[2][8] || !rst_n) check("post_data", vif.post_img_data, hist[2][7:0]);
    if (vif.frame_done)  done_cnt++;
    if (vif4.frame_done) done4_cnt++;
  endtask

  task automatic idle(input bit vs);
    drive(vs, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  // One active line with n valid pixels; tog inserts a gap after each pixel
  task automatic send_line(input int n, input bit tog, input bit merge);
    int sent;
    int cyc;
    bit v;
    sent = 0;
    cyc = 0;
    if (n == 0) repeat (3) drive(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    while (sent < n) begin
      v = tog ? (cyc % 2 == 0) : 1'b1;
      drive(1'b1, 1'b1, v, 8'($urandom), 8'($urandom), 8'($urandom));
      if (v) sent++;
      cyc++;
    end
    if (merge) begin
      idle(1'b0);
    end else begin
      // valid outside hsync must not be counted
      drive(1'b1, 1'b0, 1'b1, 8'd200, 8'd10, 8'd90);
      idle(1'b1);
      idle(1'b1);
    end
  endtask

  task automatic frame(input int nl, input int l0, input int l1, input int l2,
                       input int l3, input bit tog, input bit merge);
    int lens [4];
    lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
    done_cnt = 0;
    done4_cnt = 0;
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < nl; i++) send_line(lens[i], tog, merge && (i == nl - 1));
    if (!(merge && nl > 0)) idle(1'b0);
    repeat (4) idle(1'b0);
  endtask

  task automatic check_frame(input string tag, input int w, input int h, input int e);
    check({tag, "_done"},   done_cnt, 1);
    check({tag, "_width"},  vif.frame_width, w);
    check({tag, "_height"}, vif.frame_height, h);
    check({tag, "_err"},    vif.line_len_err, e);
  endtask

  initial begin
    hist[0] = '0; hist[1] = '0; hist[2] = '0;

    // Reset held with random inputs: everything stays at zero
    repeat (6) drive(1'($urandom), 1'($urandom), 1'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom));
    check("rst_data",   vif.post_img_data, 0);
    check("rst_width",  vif.frame_width, 0);
    check("rst_height", vif.frame_height, 0);
    check("rst_err",    vif.line_len_err, 0);
    check("rst_done",   done_cnt, 0);

    // Release in the middle of a frame: that frame is never reported
    idle(1'b1);
    rst_n = 1'b1;
    idle(1'b1);
    send_line(5, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0);
    repeat (5) idle(1'b0);
    check("partial_done", done_cnt, 0);
    check("partial_width", vif.frame_width, 0);

    // Colour points, observed three cycles after entry
    drive(1'b0, 1'b0, 1'b1, 8'd255, 8'd255, 8'd255); idle(1'b0); idle(1'b0);
    check("luma_white", vif.post_img_data, 255);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0); idle(1'b0); idle(1'b0);
    check("luma_black", vif.post_img_data, 0);
    drive(1'b0, 1'b0, 1'b1, 8'd255, 8'd0, 8'd0); idle(1'b0); idle(1'b0);
    check("luma_red", vif.post_img_data, 77);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd255, 8'd0); idle(1'b0); idle(1'b0);
    check("luma_green", vif.post_img_data, 149);
    drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd255); idle(1'b0); idle(1'b0);
    check("luma_blue", vif.post_img_data, 29);

    // Clean 8x4 with valid toggling inside each line
    frame(4, 8, 8, 8, 8, 1'b1, 1'b0);
    check_frame("f8x4", 8, 4, 0);

    // One short line sets the error flag
    frame(4, 8, 8, 7, 8, 1'b1, 1'b0);
    check_frame("f_short", 8, 4, 1);

    // Following clean frame clears it again
    frame(4, 8, 8, 8, 8, 1'b0, 1'b0);
    check_frame("f_clean", 8, 4, 0);

    // Last hsync falls together with vsync
    frame(3, 6, 6, 6, 0, 1'b0, 1'b1);
    check_frame("f_merge", 6, 3, 0);

    // An empty hsync pulse does not count as a line
    frame(4, 6, 6, 0, 6, 1'b0, 1'b0);
    check_frame("f_empty_line", 6, 3, 0);

    // Frame without any valid pixel still reports
    frame(0, 0, 0, 0, 0, 1'b0, 1'b0);
    check_frame("f_blank", 0, 0, 0);

    // 20-pixel line: the 4-bit instance saturates at 15
    frame(1, 20, 0, 0, 0, 1'b0, 1'b0);
    check_frame("f_wide", 20, 1, 0);
    check("sat4_done",   done4_cnt, 1);
    check("sat4_width",  vif4.frame_width, 15);
    check("sat4_height", vif4.frame_height, 1);
    check("sat4_err",    vif4.line_len_err, 0);

    // Outputs hold between frames
    repeat (10) idle(1'b0);
    check("hold_width", vif.frame_width, 20);
    check("hold_done",  vif.frame_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
